// File: rtl/lu_issue_ctrl.sv
// lu_issue_ctrl
//   Issue scheduler in front of lu_processor. Fetched instruction words are
//   buffered in a small circular FIFO and issued in order, one per cycle,
//   onto the processor's VLD/INSTR_WORD inputs. Outstanding loads are tracked
//   in an in-order scoreboard of destination addresses; the FIFO head is held
//   while it reads or writes a register still waiting for load data, or while
//   it is a load and the scoreboard is full.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   IN_VLD     fetch-side instruction valid
//   IN_RDY     FIFO has room (from registered count only)
//   IN_INSTR   fetch-side instruction word {CMD, RESULT, OP1, OP0}
//   VLD        registered issue valid
//   INSTR_WORD registered issued instruction (holds when VLD=0)
//   LDRDY      pulse: oldest outstanding load has returned
//   LD_PEND    number of outstanding loads
//   LD_ERR     sticky: LDRDY seen with no load outstanding
//   STALL_CNT  (only with LU_ISSUE_PERF_EN defined) saturating count of
//              cycles in which a buffered head was blocked
//
// Build option: define LU_ISSUE_PERF_EN to add the STALL_CNT counter/port.

module lu_issue_ctrl #(
    parameter int          INSTR_SIZE = 27,
    parameter int          FIFO_DEPTH = 4,
    parameter int          PEND_MAX   = 2,
    parameter logic [2:0]  LOAD_CMD   = 3'b100
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              IN_VLD,
    output logic                              IN_RDY,
    input  logic [INSTR_SIZE-1:0]             IN_INSTR,
    output logic                              VLD,
    output logic [INSTR_SIZE-1:0]             INSTR_WORD,
    input  logic                              LDRDY,
    output logic [$clog2(PEND_MAX+1)-1:0]     LD_PEND,
    output logic                              LD_ERR
`ifdef LU_ISSUE_PERF_EN
    ,
    output logic [15:0]                       STALL_CNT
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(PEND_MAX + 1);

    // Instruction FIFO
    logic [INSTR_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [CW-1:0]         count;

    // Load scoreboard: entry 0 is the oldest outstanding load
    logic [PEND_MAX-1:0][7:0] sb_addr;
    logic [PEND_MAX-1:0]      sb_vld;
    logic [PEND_MAX-1:0][7:0] sb_addr_n;
    logic [PEND_MAX-1:0]      sb_vld_n;
    logic [PW-1:0]            ld_pend;
    logic [PW-1:0]            ld_pend_n;
    logic [PW-1:0]            push_idx;

    logic [INSTR_SIZE-1:0] head;
    logic [2:0]            head_cmd;
    logic [7:0]            head_res;
    logic [7:0]            head_op1;
    logic [7:0]            head_op0;
    logic                  fifo_empty;
    logic                  head_is_load;
    logic                  hazard;
    logic                  struct_stall;
    logic                  blocked;
    logic                  issue;
    logic                  push_in;
    logic                  sb_push;
    logic                  sb_pop;

    assign head     = mem[rd_ptr];
    assign head_cmd = head[26:24];
    assign head_res = head[23:16];
    assign head_op1 = head[15:8];
    assign head_op0 = head[7:0];

    assign IN_RDY  = (count != CW'(FIFO_DEPTH));
    assign LD_PEND = ld_pend;

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < PEND_MAX; i++) begin
            if (sb_vld[i] && (sb_addr[i] == head_op0 || sb_addr[i] == head_op1 ||
                              sb_addr[i] == head_res))
                hazard = 1'b1;
        end
    end

    assign fifo_empty   = (count == '0);
    assign head_is_load = (head_cmd == LOAD_CMD);
    // Uses the pre-edge count, so a same-cycle LDRDY does not free the slot
    assign struct_stall = head_is_load && (ld_pend == PW'(PEND_MAX));
    assign blocked      = hazard || struct_stall;
    assign issue        = !fifo_empty && !blocked;
    assign push_in      = IN_VLD && IN_RDY;
    assign sb_push      = issue && head_is_load;
    assign sb_pop       = LDRDY && (ld_pend != '0);

    // Scoreboard next state: pop shifts the queue down one slot, then a new
    // load lands just above the surviving entries.
    always_comb begin
        sb_addr_n = sb_addr;
        sb_vld_n  = sb_vld;
        if (sb_pop) begin
            for (int unsigned i = 0; i + 1 < PEND_MAX; i++) begin
                sb_addr_n[i] = sb_addr[i+1];
                sb_vld_n[i]  = sb_vld[i+1];
            end
            sb_vld_n[PEND_MAX-1] = 1'b0;
        end
        push_idx = ld_pend - PW'(sb_pop);
        if (sb_push) begin
            for (int unsigned i = 0; i < PEND_MAX; i++) begin
                if (PW'(i) == push_idx) begin
                    sb_addr_n[i] = head_res;
                    sb_vld_n[i]  = 1'b1;
                end
            end
        end
        ld_pend_n = ld_pend + PW'(sb_push) - PW'(sb_pop);
    end

    always_ff @(posedge clk) begin
        if (push_in)
            mem[wr_ptr] <= IN_INSTR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            sb_addr    <= '0;
            sb_vld     <= '0;
            ld_pend    <= '0;
            LD_ERR     <= 1'b0;
            VLD        <= 1'b0;
            INSTR_WORD <= '0;
        end else begin
            if (push_in)
                wr_ptr <= wr_ptr + AW'(1);
            if (issue) begin
                rd_ptr     <= rd_ptr + AW'(1);
                INSTR_WORD <= head;
            end
            VLD     <= issue;
            count   <= count + CW'(push_in) - CW'(issue);
            sb_addr <= sb_addr_n;
            sb_vld  <= sb_vld_n;
            ld_pend <= ld_pend_n;
            if (LDRDY && ld_pend == '0)
                LD_ERR <= 1'b1;
        end
    end

`ifdef LU_ISSUE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            STALL_CNT <= '0;
        else if (!fifo_empty && blocked && STALL_CNT != 16'hFFFF)
            STALL_CNT <= STALL_CNT + 16'd1;
    end
`endif

endmodule

// File: tb/tb_lu_issue_ctrl.sv
// tb_lu_issue_ctrl
//   Self-checking bench for lu_issue_ctrl. A behavioural model built on
//   SystemVerilog queues (instruction buffer, pending-load addresses) tracks
//   the expected outputs cycle by cycle; scenario tasks compare the DUT to it
//   and to hand-derived constants for the directed cases.

module tb_lu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [26:0] in_instr = '0;
    logic        vld;
    logic [26:0] instr_word;
    logic        ldrdy = 1'b0;
    logic [1:0]  ld_pend;
    logic        ld_err;
`ifdef LU_ISSUE_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lu_issue_ctrl #(.INSTR_SIZE(27), .FIFO_DEPTH(4), .PEND_MAX(2), .LOAD_CMD(3'b100)) dut (
        .clk        (clk),
        .rst        (rst),
        .IN_VLD     (in_vld),
        .IN_RDY     (in_rdy),
        .IN_INSTR   (in_instr),
        .VLD        (vld),
        .INSTR_WORD (instr_word),
        .LDRDY      (ldrdy),
        .LD_PEND    (ld_pend),
        .LD_ERR     (ld_err)
`ifdef LU_ISSUE_PERF_EN
        ,
        .STALL_CNT  (stall_cnt)
`endif
    );

    logic [31:0] dut_vec;
    assign dut_vec = {vld, instr_word, in_rdy, ld_pend, ld_err};

    // ---------------- reference model ----------------
    logic [26:0] fq[$];     // buffered instructions, oldest first
    logic [7:0]  pq[$];     // outstanding load destinations, oldest first
    logic [26:0] src[$];    // fetch-side words still to be offered
    bit          m_vld;
    logic [26:0] m_word;
    bit          m_err;
    int          m_stall;

    function automatic logic [31:0] exp_vec();
        return {m_vld, m_word, (fq.size() < 4) ? 1'b1 : 1'b0, 2'(pq.size()), m_err};
    endfunction

    task automatic model_clear();
        fq.delete();
        pq.delete();
        src.delete();
        m_vld = 0;
        m_word = '0;
        m_err = 0;
        m_stall = 0;
    endtask

    task automatic model_step(input bit iv, input logic [26:0] ins, input bit rdy,
                              output bit acc);
        bit          issue;
        bit          blk;
        logic [26:0] h;
        int          pre_p;
        pre_p = pq.size();
        acc = iv && (fq.size() < 4);
        issue = 0;
        h = '0;
        if (fq.size() > 0) begin
            h = fq[0];
            blk = (h[26:24] == 3'b100) && (pre_p == 2);
            foreach (pq[i])
                if (pq[i] == h[7:0] || pq[i] == h[15:8] || pq[i] == h[23:16])
                    blk = 1;
            issue = !blk;
            if (blk && m_stall < 65535)
                m_stall++;
        end
        if (rdy) begin
            if (pre_p > 0) pq.delete(0);
            else m_err = 1;
        end
        if (issue) begin
            fq.delete(0);
            m_vld = 1;
            m_word = h;
            if (h[26:24] == 3'b100) pq.push_back(h[23:16]);
        end else begin
            m_vld = 0;
        end
        if (acc) fq.push_back(ins);
    endtask

    // One clock: offer src head (if any) plus LDRDY, advance model, settle.
    task automatic tick(input bit rdy);
        bit          acc;
        bit          iv;
        logic [26:0] ins;
        iv = (src.size() > 0);
        ins = iv ? src[0] : 27'h0;
        in_vld = iv;
        in_instr = ins;
        ldrdy = rdy;
        model_step(iv, ins, rdy, acc);
        @(posedge clk);
        #1;
        if (acc) src.delete(0);
        in_vld = 0;
        ldrdy = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_clear();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec !== {1'b1 ^ 1'b1, 27'h0, 1'b1, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", dut_vec, {1'b0, 27'h0, 1'b1, 2'd0, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        logic [26:0] w [3];
        w[0] = 27'h0_03_02_01;
        w[1] = 27'h0_06_05_04;
        w[2] = 27'h0_09_08_07;
        do_reset();
        for (int i = 0; i < 3; i++) src.push_back(w[i]);
        for (int c = 1; c <= 5; c++) begin
            tick(0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL b2b_model cyc=%0d got=%h want=%h", c, dut_vec, exp_vec());
            end
            if (c >= 2 && c <= 4) begin
                checks++;
                if ({vld, instr_word} !== {1'b1, w[c-2]}) begin
                    failures++;
                    $display("FAIL b2b_word cyc=%0d got=%b/%h want=1/%h", c, vld, instr_word, w[c-2]);
                end
            end
        end
    endtask

    task automatic test_load_use();
        int hold;
        int held;
        hold = int'($urandom_range(1, 6));
        held = 0;
        do_reset();
        src.push_back(27'h4_05_00_00);
        src.push_back(27'h0_07_05_06);
        tick(0);
        tick(0);
        checks++;
        if ({vld, instr_word, ld_pend} !== {1'b1, 27'h4_05_00_00, 2'd1}) begin
            failures++;
            $display("FAIL ldu_load_issue got=%b/%h/%0d want=1/4050000/1", vld, instr_word, ld_pend);
        end
        for (int c = 0; c <= hold; c++) begin
            tick(c == hold);
            held++;
            checks++;
            if (vld !== 1'b0 || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL ldu_hold cyc=%0d got=%h want=%h", c, dut_vec, exp_vec());
            end
        end
        tick(0);
        checks++;
        if ({vld, instr_word, ld_pend} !== {1'b1, 27'h0_07_05_06, 2'd0}) begin
            failures++;
            $display("FAIL ldu_release got=%b/%h/%0d want=1/0070506/0", vld, instr_word, ld_pend);
        end
`ifdef LU_ISSUE_PERF_EN
        checks++;
        if (stall_cnt !== 16'(held)) begin
            failures++;
            $display("FAIL ldu_stall_cnt got=%0d want=%0d", stall_cnt, held);
        end
`endif
    endtask

    task automatic test_struct_stall();
        do_reset();
        src.push_back(27'h4_10_00_00);
        src.push_back(27'h4_11_00_00);
        src.push_back(27'h4_12_00_00);
        for (int c = 1; c <= 6; c++) begin
            tick(c == 5);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL struct_model cyc=%0d got=%h want=%h", c, dut_vec, exp_vec());
            end
        end
        checks++;
        if ({vld, instr_word, ld_pend} !== {1'b1, 27'h4_12_00_00, 2'd2}) begin
            failures++;
            $display("FAIL struct_third got=%b/%h/%0d want=1/4120000/2", vld, instr_word, ld_pend);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        src.push_back(27'h4_05_00_00);
        for (int i = 0; i < 5; i++) src.push_back({3'b000, 8'(8'h20 + i), 8'h05, 8'h01});
        for (int c = 1; c <= 5; c++) tick(0);
        checks++;
        if (in_rdy !== 1'b0 || src.size() != 1) begin
            failures++;
            $display("FAIL full_rdy got=%b left=%0d want=0 left=1", in_rdy, src.size());
        end
        for (int c = 0; c < 3; c++) begin
            tick(c == 2);
            checks++;
            if (dut_vec !== exp_vec() || src.size() != 1) begin
                failures++;
                $display("FAIL full_hold cyc=%0d got=%h want=%h", c, dut_vec, exp_vec());
            end
        end
        tick(0);
        checks++;
        if ({vld, in_rdy} !== 2'b11 || src.size() != 1) begin
            failures++;
            $display("FAIL full_first_issue got=%b%b left=%0d want=11 left=1", vld, in_rdy, src.size());
        end
        tick(0);
        checks++;
        if (src.size() != 0 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL full_fifth_taken got=%h left=%0d want=%h", dut_vec, src.size(), exp_vec());
        end
    endtask

    task automatic test_spurious();
        do_reset();
        tick(1);
        checks++;
        if ({ld_err, ld_pend} !== {1'b1, 2'd0}) begin
            failures++;
            $display("FAIL spur_err got=%b/%0d want=1/0", ld_err, ld_pend);
        end
        src.push_back(27'h4_33_00_00);
        src.push_back(27'h0_34_33_00);
        for (int c = 0; c < 6; c++) begin
            tick(c == 3);
            checks++;
            if (ld_err !== 1'b1 || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL spur_traffic cyc=%0d got=%h want=%h", c, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] cmds [5];
        cmds[0] = 3'b000; cmds[1] = 3'b001; cmds[2] = 3'b010;
        cmds[3] = 3'b100; cmds[4] = 3'b100;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (src.size() < 2 && $urandom_range(0, 9) < 7)
                src.push_back({cmds[$urandom_range(0, 4)], 8'($urandom_range(0, 7)),
                               8'($urandom_range(0, 7)), 8'($urandom_range(0, 7))});
            tick($urandom_range(0, 9) < 2);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL rand cyc=%0d got=%h want=%h", c, dut_vec, exp_vec());
            end
`ifdef LU_ISSUE_PERF_EN
            checks++;
            if (stall_cnt !== 16'(m_stall)) begin
                failures++;
                $display("FAIL rand_stall cyc=%0d got=%0d want=%0d", c, stall_cnt, m_stall);
            end
`endif
        end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        src.push_back(27'h4_05_00_00);
        src.push_back(27'h0_07_05_06);
        src.push_back(27'h0_08_05_06);
        src.push_back(27'h0_09_05_06);
        tick(0);
        tick(0);
        tick(0);
        tick(0);
        checks++;
        if (fq.size() != 3 || pq.size() != 1 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL mid_setup got=%h want=%h", dut_vec, exp_vec());
        end
        rst = 1;
        #2;
        checks++;
        if (dut_vec !== {1'b0, 27'h0, 1'b1, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL mid_async_reset got=%h want=%h", dut_vec, {1'b0, 27'h0, 1'b1, 2'd0, 1'b0});
        end
        @(posedge clk);
        #1;
        rst = 0;
        model_clear();
        tick(0);
        checks++;
        if (dut_vec !== {1'b0, 27'h0, 1'b1, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL mid_after_reset got=%h want=%h", dut_vec, {1'b0, 27'h0, 1'b1, 2'd0, 1'b0});
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_struct_stall();
        test_fifo_full();
        test_spurious();
        test_midstream_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
